// File: rtl/pkg_cordic_sincos.sv
// Shared constants and helpers for the CORDIC sin/cos pipeline.
package pkg_cordic_sincos;

  localparam int unsigned DEFAULT_BITS     = 16;
  localparam int unsigned DEFAULT_OUT_BITS = 12;
  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam int unsigned CALC_W           = 32;

  // Round half up from in_bits to out_bits, then clamp to the symmetric range.
  function automatic logic signed [CALC_W-1:0] round_sat(
    input logic signed [CALC_W-1:0] x,
    input int unsigned              in_bits,
    input int unsigned              out_bits
  );
    int unsigned              s;
    logic signed [CALC_W-1:0] half;
    logic signed [CALC_W-1:0] lim;
    logic signed [CALC_W-1:0] r;
    s    = in_bits - out_bits;
    half = $signed(CALC_W'(1) << (s - 1));
    lim  = $signed((CALC_W'(1) << (out_bits - 1)) - CALC_W'(1));
    r    = (x + half) >>> s;
    if (r > lim) begin
      r = lim;
    end else if (r < -lim) begin
      r = -lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_sincos_out_fifo.sv
// Small synchronous FIFO; full/empty come from the occupancy count.
module cordic_sincos_out_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since reads are masked when empty.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cordic_sincos_postprocess.sv
// Final CORDIC stage: quadrant sign fix, round/saturate, output FIFO and stall control.
module cordic_sincos_postprocess
  import pkg_cordic_sincos::*;
#(
  parameter int unsigned BITS     = DEFAULT_BITS,
  parameter int unsigned OUT_BITS = DEFAULT_OUT_BITS,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pipeline_en,
  output logic                     o_pipeline_en,
  input  logic                     i_valid,
  input  logic                     i_sign,
  input  logic signed [BITS-1:0]   i_cos,
  input  logic signed [BITS-1:0]   i_sin,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*OUT_BITS-1:0]    o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam logic signed [BITS-1:0] MAX_IN = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] MIN_IN = {1'b1, {(BITS-1){1'b0}}};

  logic                       fifo_full;
  logic                       fifo_empty;
  logic signed [BITS-1:0]     cos_fix_c;
  logic signed [BITS-1:0]     sin_fix_c;
  logic                       valid_p1;
  logic signed [BITS-1:0]     cos_p1;
  logic signed [BITS-1:0]     sin_p1;
  logic                       valid_p2;
  logic signed [OUT_BITS-1:0] cos_p2;
  logic signed [OUT_BITS-1:0] sin_p2;

  // Conservative stall: a full FIFO blocks the pipeline even if it pops this cycle.
  assign o_pipeline_en = i_pipeline_en & ~fifo_full;
  assign o_valid       = ~fifo_empty;

  // Quadrant inversion; the most negative input negates to the most positive.
  always_comb begin
    cos_fix_c = i_cos;
    sin_fix_c = i_sin;
    if (i_sign) begin
      cos_fix_c = (i_cos == MIN_IN) ? MAX_IN : -i_cos;
      sin_fix_c = (i_sin == MIN_IN) ? MAX_IN : -i_sin;
    end
  end

  // P1 sign-correction and P2 round/saturate stages, advancing only on enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_p1 <= 1'b0;
      cos_p1   <= '0;
      sin_p1   <= '0;
      valid_p2 <= 1'b0;
      cos_p2   <= '0;
      sin_p2   <= '0;
    end else if (o_pipeline_en) begin
      valid_p1 <= i_valid;
      cos_p1   <= cos_fix_c;
      sin_p1   <= sin_fix_c;
      valid_p2 <= valid_p1;
      cos_p2   <= OUT_BITS'(round_sat(CALC_W'(cos_p1), BITS, OUT_BITS));
      sin_p2   <= OUT_BITS'(round_sat(CALC_W'(sin_p1), BITS, OUT_BITS));
    end
  end

  cordic_sincos_out_fifo #(
    .WIDTH (2 * OUT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (o_pipeline_en & valid_p2),
    .pop   (i_ready),
    .wdata ({sin_p2, cos_p2}),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

endmodule

// File: tb/tb_cordic_sincos_postprocess.sv
// Bench for cordic_sincos_postprocess: vector table, corner sequences, random traffic vs queue model.
module tb_cordic_sincos_postprocess;

  localparam int unsigned BITS     = 16;
  localparam int unsigned OUT_BITS = 12;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned S        = BITS - OUT_BITS;
  localparam int          IN_MAX   = (1 << (BITS - 1)) - 1;
  localparam int          OUT_LIM  = (1 << (OUT_BITS - 1)) - 1;

  logic                     i_clk;
  logic                     i_rst;
  logic                     i_pipeline_en;
  logic                     o_pipeline_en;
  logic                     i_valid;
  logic                     i_sign;
  logic signed [BITS-1:0]   i_cos;
  logic signed [BITS-1:0]   i_sin;
  logic                     o_valid;
  logic                     i_ready;
  logic [2*OUT_BITS-1:0]    o_data;
  logic [$clog2(DEPTH):0]   o_count;

  cordic_sincos_postprocess #(
    .BITS     (BITS),
    .OUT_BITS (OUT_BITS),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pipeline_en (i_pipeline_en),
    .o_pipeline_en (o_pipeline_en),
    .i_valid       (i_valid),
    .i_sign        (i_sign),
    .i_cos         (i_cos),
    .i_sin         (i_sin),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_count       (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_pops = 0;

  // Behavioural model: two pipeline slots holding raw inputs, FIFO of expected words.
  typedef struct {
    bit v;
    bit sgn;
    int c;
    int s;
  } slot_t;

  slot_t p1, p2;
  int    q_c[$];
  int    q_s[$];

  typedef struct {
    bit                   sgn;
    logic [BITS-1:0]      c;
    logic [BITS-1:0]      s;
    logic [OUT_BITS-1:0]  ec;
    logic [OUT_BITS-1:0]  es;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget exhausted (t=%0t)", name, $time);
  endtask

  // Negate with saturation, round half up by real division, clamp symmetrically.
  function automatic int ref_word(input int x, input bit sgn);
    int  v;
    real r;
    v = sgn ? -x : x;
    if (v > IN_MAX) v = IN_MAX;
    r = $floor((v + 2.0 ** (S - 1)) / (2.0 ** S));
    v = $rtoi(r);
    if (v > OUT_LIM) v = OUT_LIM;
    if (v < -OUT_LIM) v = -OUT_LIM;
    return v;
  endfunction

  function automatic logic [2*OUT_BITS-1:0] model_head();
    if (q_c.size() == 0) return '0;
    return {OUT_BITS'(q_s[0]), OUT_BITS'(q_c[0])};
  endfunction

  // One clock: drive at negedge, check enable, step model at posedge, check outputs at next negedge.
  task automatic cycle(input bit rst, input bit ipe, input bit v, input bit sgn,
                       input logic [BITS-1:0] c, input logic [BITS-1:0] s,
                       input bit rdy, output bit en_m);
    bit pop_m;
    i_rst = rst; i_pipeline_en = ipe; i_valid = v; i_sign = sgn;
    i_cos = c; i_sin = s; i_ready = rdy;
    #1;
    en_m  = ipe && (q_c.size() != DEPTH);
    pop_m = (q_c.size() > 0) && rdy;
    chk("pipeline_en", 32'(o_pipeline_en), 32'(en_m));
    if (o_valid && rdy) dut_pops++;
    @(posedge i_clk);
    if (rst) begin
      q_c.delete(); q_s.delete();
      p1.v = 0; p2.v = 0;
    end else begin
      if (pop_m) begin
        void'(q_c.pop_front()); void'(q_s.pop_front());
      end
      if (en_m) begin
        if (p2.v) begin
          q_c.push_back(ref_word(p2.c, p2.sgn));
          q_s.push_back(ref_word(p2.s, p2.sgn));
        end
        p2 = p1;
        p1.v = v; p1.sgn = sgn;
        p1.c = int'($signed(c)); p1.s = int'($signed(s));
      end
    end
    @(negedge i_clk);
    chk("o_valid", 32'(o_valid), 32'(q_c.size() > 0));
    chk("o_count", 32'(o_count), 32'(q_c.size()));
    chk("o_data", 32'(o_data), 32'(model_head()));
  endtask

  function automatic logic [BITS-1:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return BITS'($urandom);
    endcase
  endfunction

  vec_t vecs[11];
  bit   en;

  initial begin
    vecs[0]  = '{0, 16'h4000, 16'h0000, 12'h400, 12'h000};
    vecs[1]  = '{1, 16'h4000, 16'h0000, 12'hC00, 12'h000};
    vecs[2]  = '{0, 16'h0008, 16'h0000, 12'h001, 12'h000};
    vecs[3]  = '{0, 16'h0007, 16'h0000, 12'h000, 12'h000};
    vecs[4]  = '{0, 16'hFFF8, 16'h0000, 12'h000, 12'h000};
    vecs[5]  = '{0, 16'hFFF7, 16'h0000, 12'hFFF, 12'h000};
    vecs[6]  = '{0, 16'h7FFF, 16'h0000, 12'h7FF, 12'h000};
    vecs[7]  = '{0, 16'h8000, 16'h0000, 12'h801, 12'h000};
    vecs[8]  = '{1, 16'h8000, 16'h0000, 12'h7FF, 12'h000};
    vecs[9]  = '{1, 16'h0000, 16'h4000, 12'h000, 12'hC00};
    vecs[10] = '{1, 16'h0010, 16'h8000, 12'hFFF, 12'h7FF};

    p1.v = 0; p2.v = 0;
    i_rst = 1; i_pipeline_en = 1; i_valid = 0; i_sign = 0;
    i_cos = '0; i_sin = '0; i_ready = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_count", 32'(o_count), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_pipeline_en", 32'(o_pipeline_en), 32'd1);
    @(negedge i_clk);

    // Table vectors: single result, latency and value checked explicitly.
    foreach (vecs[k]) begin
      cycle(0, 1, 1, vecs[k].sgn, vecs[k].c, vecs[k].s, 0, en);
      cycle(0, 1, 0, 0, '0, '0, 0, en);
      chk("lat_before_3rd_edge", 32'(o_valid), 32'd0);
      cycle(0, 1, 0, 0, '0, '0, 0, en);
      chk("lat_after_3rd_edge", 32'(o_valid), 32'd1);
      chk($sformatf("vec%0d_cos", k), 32'(o_data[OUT_BITS-1:0]), 32'(vecs[k].ec));
      chk($sformatf("vec%0d_sin", k), 32'(o_data[2*OUT_BITS-1:OUT_BITS]), 32'(vecs[k].es));
      cycle(0, 1, 0, 0, '0, '0, 1, en);
    end

    // Backpressure: eight held-until-accepted inputs with the consumer stalled, then released.
    begin
      int              accepted = 0;
      int              g;
      bit              sg;
      logic [BITS-1:0] c, s;
      dut_pops = 0;
      sg = 1'($urandom); c = rnd_word(); s = rnd_word();
      for (int t = 0; t < 12; t++) begin
        cycle(0, 1, accepted < 8, sg, c, s, 0, en);
        if (en && accepted < 8) begin
          accepted++;
          sg = 1'($urandom); c = rnd_word(); s = rnd_word();
        end
      end
      chk("bp_full_count", 32'(o_count), 32'(DEPTH));
      chk("bp_en_low", 32'(o_pipeline_en), 32'd0);
      chk("bp_held_accepts", 32'(accepted), 32'd6);
      g = 0;
      while ((accepted < 8 || q_c.size() > 0 || p1.v || p2.v) && g < 60) begin
        cycle(0, 1, accepted < 8, sg, c, s, 1, en);
        if (en && accepted < 8) begin
          accepted++;
          sg = 1'($urandom); c = rnd_word(); s = rnd_word();
        end
        g++;
      end
      if (g >= 60) timeout("bp_drain");
      chk("bp_pop_total", 32'(dut_pops), 32'd8);
    end

    // Reset mid-stream with three queued results and both stages occupied.
    begin
      int g = 0;
      while (q_c.size() < 3 && g < 20) begin
        cycle(0, 1, 1, 1'($urandom), rnd_word(), rnd_word(), 0, en);
        g++;
      end
      if (g >= 20) timeout("rst_fill");
      chk("pre_rst_count", 32'(o_count), 32'd3);
      cycle(1, 1, 1, 0, 16'h1234, 16'h4321, 0, en);
      chk("midrst_o_valid", 32'(o_valid), 32'd0);
      chk("midrst_o_count", 32'(o_count), 32'd0);
      chk("midrst_o_data", 32'(o_data), 32'd0);
      dut_pops = 0;
      repeat (6) cycle(0, 1, 0, 0, '0, '0, 1, en);
      chk("no_stale_after_rst", 32'(dut_pops), 32'd0);
    end

    // Random traffic including enable gaps and consumer stalls.
    for (int t = 0; t < 400; t++) begin
      cycle(0, $urandom_range(0, 5) != 0, 1'($urandom), 1'($urandom),
            rnd_word(), rnd_word(), $urandom_range(0, 2) != 0, en);
    end
    begin
      int g = 0;
      while ((q_c.size() > 0 || p1.v || p2.v) && g < 40) begin
        cycle(0, 1, 0, 0, '0, '0, 1, en);
        g++;
      end
      if (g >= 40) timeout("final_drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
